// File: rtl/des_sync_pkg.sv
// des_sync_pkg: word width, receiver state encoding and default frame marker for des_sync
package des_sync_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] SYNC_DEFAULT = 16'hA5C3;
  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;
endpackage

// File: rtl/des_sync_shift.sv
// des_sync_shift: serial capture register, bit-in-word counter and the 16-bit window ending at the current bit
module des_sync_shift
  import des_sync_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              datain,
  input  logic              load,
  output logic [WORD_W-1:0] w,
  output logic [3:0]        bit_cnt
);
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  assign w = {shift_q, datain};
  assign bit_cnt = bit_cnt_q;
  always_comb begin
    shift_d = w[WORD_W-2:0];
    bit_cnt_d = load ? 4'd0 : bit_cnt_q + 4'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/des_sync.sv
// des_sync: serial-to-parallel receiver with sync-word framing (HUNT/CHECK/LOCK).
// Define DES_SYNC_ERRCNT_EN to build the saturating sync-miss counter on err_cnt.
module des_sync
  import des_sync_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_DEFAULT,
  parameter int                FRAME_LEN = 8,
  parameter int                MISS_MAX  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              datain,
  output logic [WORD_W-1:0] dataout,
  output logic              valid,
  output logic              sof,
  output logic              locked,
  output logic [7:0]        err_cnt
);
  localparam int IW = $clog2(FRAME_LEN);
  state_t state_q, state_d;
  logic [IW-1:0] word_idx_q, word_idx_d, idx_nx;
  logic [3:0] miss_q, miss_d;
  logic [WORD_W-1:0] dataout_q, dataout_d;
  logic valid_q, valid_d, sof_q, sof_d;
  logic load, done, match, sync_slot;
  logic [WORD_W-1:0] w;
  logic [3:0] bit_cnt;
  des_sync_shift u_shift (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .load    (load),
    .w       (w),
    .bit_cnt (bit_cnt)
  );
  always_comb begin
    done = bit_cnt == 4'd15;
    match = w == SYNC_WORD;
    sync_slot = done && word_idx_q == '0;
    idx_nx = (word_idx_q == IW'(FRAME_LEN - 1)) ? '0 : word_idx_q + IW'(1);
    state_d = state_q;
    word_idx_d = done ? idx_nx : word_idx_q;
    miss_d = miss_q;
    dataout_d = dataout_q;
    valid_d = 1'b0;
    sof_d = 1'b0;
    load = 1'b0;
    case (state_q)
      HUNT: if (match) begin
        state_d = CHECK;
        load = 1'b1;
        word_idx_d = IW'(1);
      end
      CHECK: if (sync_slot) begin
        state_d = match ? LOCK : HUNT;
        miss_d = '0;
      end
      LOCK: if (done && word_idx_q != '0) begin
        dataout_d = w;
        valid_d = 1'b1;
        sof_d = word_idx_q == IW'(1);
      end else if (sync_slot) begin
        miss_d = match ? 4'd0 : miss_q + 4'd1;
        state_d = (!match && miss_d == 4'(MISS_MAX)) ? HUNT : LOCK;
      end
      default: state_d = HUNT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      word_idx_q <= '0;
      miss_q <= '0;
      dataout_q <= '0;
      valid_q <= 1'b0;
      sof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_idx_q <= word_idx_d;
      miss_q <= miss_d;
      dataout_q <= dataout_d;
      valid_q <= valid_d;
      sof_q <= sof_d;
    end
  end
  assign dataout = dataout_q;
  assign valid = valid_q;
  assign sof = sof_q;
  assign locked = state_q == LOCK;
`ifdef DES_SYNC_ERRCNT_EN
  logic [7:0] err_q, err_d;
  always_comb err_d = (state_q == LOCK && sync_slot && !match && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else err_q <= err_d;
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_des_sync.sv
// tb_des_sync: scenario tasks replaying bit streams into des_sync against a frame-level reference model
module tb_des_sync;
  localparam int MAXN = 70000;
  localparam int FL = 8;
  localparam int MM = 2;
  localparam logic [15:0] SYNC = 16'hA5C3;
`ifdef DES_SYNC_ERRCNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, datain = 1'b0;
  logic [15:0] dataout;
  logic valid, sof, locked;
  logic [7:0] err_cnt;
  int cmp = 0, bad = 0, n = 0;
  bit bits [MAXN];
  logic [26:0] obs [MAXN];
  logic [26:0] exp_o [MAXN];
  bit mv [MAXN], ms [MAXN], ml [MAXN], mm [MAXN];
  logic [15:0] md [MAXN];

  des_sync dut (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .dataout (dataout),
    .valid   (valid),
    .sof     (sof),
    .locked  (locked),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] win(input int t);
    logic [15:0] r = '0;
    for (int i = 15; i >= 0; i--) r = {r[14:0], (t - i >= 0) ? bits[(t - i >= 0) ? t - i : 0] : 1'b0};
    return r;
  endfunction

  task automatic push_word(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      bits[n] = v[i];
      n++;
    end
  endtask

  task automatic push_rand(input int k);
    for (int i = 0; i < k; i++) begin
      bits[n] = 1'($urandom);
      n++;
    end
  endtask

  task automatic push_frame(input logic [15:0] s, input bit rnd);
    push_word(s);
    for (int j = 1; j < FL; j++) push_word(rnd ? 16'($urandom) : 16'(j));
  endtask

  // Whole-stream model: find a sync, confirm it one frame later, then walk frame by frame
  task automatic model();
    int pos, t, k, miss;
    bit lost;
    logic [7:0] c;
    logic [15:0] last;
    for (int i = 0; i < n; i++) begin
      mv[i] = 0; ms[i] = 0; ml[i] = 0; mm[i] = 0; md[i] = '0;
    end
    pos = 0;
    while (pos < n) begin
      t = pos;
      while (t < n && win(t) != SYNC) t++;
      k = t + 16 * FL;
      if (k >= n) break;
      if (win(k) == SYNC) begin
        miss = 0;
        lost = 0;
        while (k < n && !lost) begin
          for (int j = 1; j < FL; j++)
            if (k + 16 * j < n) begin
              mv[k + 16 * j] = 1;
              md[k + 16 * j] = win(k + 16 * j);
              ms[k + 16 * j] = (j == 1);
            end
          for (int e = k; e < k + 16 * FL && e < n; e++) ml[e] = 1;
          k += 16 * FL;
          if (k < n && win(k) != SYNC) begin
            mm[k] = 1;
            miss++;
            lost = (miss == MM);
          end else miss = 0;
        end
      end
      pos = k + 1;
    end
    c = '0;
    last = '0;
    for (int i = 0; i < n; i++) begin
      if (mv[i]) last = md[i];
      if (mm[i] && c != 8'hFF) c++;
      exp_o[i] = {mv[i], ms[i], ml[i], ERR_ON ? c : 8'h00, last};
    end
  endtask

  task automatic do_reset();
    datain = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic play();
    for (int t = 0; t < n; t++) begin
      datain = bits[t];
      @(posedge clk);
      #1;
      obs[t] = {valid, sof, locked, err_cnt, dataout};
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    datain = 1'b1;
    @(negedge clk);
    cmp++;
    if ({valid, sof, locked, err_cnt, dataout} !== 27'h0) begin
      bad++;
      $display("FAIL reset_state got %h want 0", {valid, sof, locked, err_cnt, dataout});
    end
    do_reset();
  endtask

  task automatic test_clean_lock();
    int nv = 0, ns = 0;
    n = 0;
    push_rand(5);
    push_frame(SYNC, 0);
    push_frame(SYNC, 0);
    model();
    do_reset();
    play();
    for (int t = 0; t < n; t++) begin
      cmp++;
      if (obs[t] !== exp_o[t]) begin bad++; $display("FAIL clean_lock t=%0d got %h want %h", t, obs[t], exp_o[t]); end
      nv += int'(obs[t][26]);
      ns += int'(obs[t][25]);
    end
    cmp += 4;
    if (obs[147][24] !== 1'b0 || obs[148][24] !== 1'b1) begin bad++; $display("FAIL clean_lock_rise got %b%b want 01", obs[147][24], obs[148][24]); end
    if (nv != 7) begin bad++; $display("FAIL clean_lock_valid_count got %0d want 7", nv); end
    if (ns != 1) begin bad++; $display("FAIL clean_lock_sof_count got %0d want 1", ns); end
    if (obs[164] !== {3'b111, 8'h00, 16'h0001}) begin bad++; $display("FAIL clean_lock_first got %h want %h", obs[164], {3'b111, 8'h00, 16'h0001}); end
  endtask

  task automatic test_false_sync();
    int nv = 0, nl = 0;
    n = 0;
    push_rand(5);
    push_frame(SYNC, 1);
    push_word(16'h1234);
    for (int i = 0; i < 4; i++) push_word(16'h0000);
    model();
    do_reset();
    play();
    for (int t = 0; t < n; t++) begin
      cmp++;
      if (obs[t] !== exp_o[t]) begin bad++; $display("FAIL false_sync t=%0d got %h want %h", t, obs[t], exp_o[t]); end
      nv += int'(obs[t][26]);
      nl += int'(obs[t][24]);
    end
    cmp++;
    if (nv != 0 || nl != 0) begin bad++; $display("FAIL false_sync_quiet got valid=%0d locked=%0d want 0/0", nv, nl); end
  endtask

  task automatic test_miss_tolerance();
    n = 0;
    push_rand(5);
    push_frame(SYNC, 1);
    push_frame(SYNC, 1);
    push_frame(16'hFFFF, 1);
    push_frame(SYNC, 1);
    push_frame(16'hFFFF, 1);
    push_frame(16'hFFFF, 1);
    model();
    do_reset();
    play();
    for (int t = 0; t < n; t++) begin
      cmp++;
      if (obs[t] !== exp_o[t]) begin bad++; $display("FAIL miss_tol t=%0d got %h want %h", t, obs[t], exp_o[t]); end
    end
    cmp += 4;
    if (obs[276][24] !== 1'b1 || obs[276][23:16] !== (ERR_ON ? 8'd1 : 8'd0)) begin bad++; $display("FAIL miss_one got locked=%b err=%0d", obs[276][24], obs[276][23:16]); end
    if (obs[292][26] !== 1'b1) begin bad++; $display("FAIL miss_one_payload got valid=%b want 1", obs[292][26]); end
    if (obs[659][24] !== 1'b1 || obs[660][24] !== 1'b0) begin bad++; $display("FAIL miss_two_fall got %b%b want 10", obs[659][24], obs[660][24]); end
    if (obs[660][23:16] !== (ERR_ON ? 8'd3 : 8'd0)) begin bad++; $display("FAIL miss_two_err got %0d want %0d", obs[660][23:16], ERR_ON ? 3 : 0); end
  endtask

  task automatic test_sync_in_payload();
    n = 0;
    push_rand(5);
    push_frame(SYNC, 1);
    push_frame(SYNC, 1);
    push_word(SYNC);
    for (int j = 1; j < FL; j++) push_word(j == 3 ? SYNC : 16'(16'h1111 * j));
    push_frame(SYNC, 0);
    model();
    do_reset();
    play();
    for (int t = 0; t < n; t++) begin
      cmp++;
      if (obs[t] !== exp_o[t]) begin bad++; $display("FAIL sync_payload t=%0d got %h want %h", t, obs[t], exp_o[t]); end
    end
    cmp += 2;
    if (obs[324] !== {3'b101, 8'h00, SYNC}) begin bad++; $display("FAIL sync_payload_word got %h want %h", obs[324], {3'b101, 8'h00, SYNC}); end
    if (obs[420] !== {3'b111, 8'h00, 16'h0001}) begin bad++; $display("FAIL sync_payload_align got %h want %h", obs[420], {3'b111, 8'h00, 16'h0001}); end
  endtask

  task automatic test_reset_mid();
    n = 0;
    push_rand(5);
    push_frame(SYNC, 0);
    push_frame(SYNC, 0);
    push_word(SYNC);
    for (int j = 1; j <= 3; j++) push_word(16'(j));
    for (int i = 15; i > 6; i--) begin bits[n] = (i % 2) == 0; n++; end
    do_reset();
    play();
    cmp++;
    if (obs[n - 1][24] !== 1'b1 || obs[n - 1][15:0] !== 16'h0003) begin bad++; $display("FAIL reset_mid_pre got %h want locked with 0003", obs[n - 1]); end
    datain = 1'b1;
    #2 rst = 1'b1;
    #1;
    cmp++;
    if ({valid, sof, locked, err_cnt, dataout} !== 27'h0) begin bad++; $display("FAIL reset_mid_clear got %h want 0", {valid, sof, locked, err_cnt, dataout}); end
    n = 0;
    push_frame(SYNC, 1);
    push_frame(SYNC, 1);
    push_frame(SYNC, 1);
    model();
    do_reset();
    play();
    for (int t = 0; t < n; t++) begin
      cmp++;
      if (obs[t] !== exp_o[t]) begin bad++; $display("FAIL reset_mid_relock t=%0d got %h want %h", t, obs[t], exp_o[t]); end
    end
    cmp++;
    if (obs[142][24] !== 1'b0 || obs[143][24] !== 1'b1) begin bad++; $display("FAIL reset_mid_two_syncs got %b%b want 01", obs[142][24], obs[143][24]); end
  endtask

  task automatic test_back_to_back();
    n = 0;
    push_rand($urandom_range(0, 31));
    push_frame(SYNC, 1);
    push_frame(SYNC, 1);
    for (int f = 0; f < 14; f++) push_frame(($urandom_range(0, 3) == 0) ? 16'h5A3C ^ 16'($urandom_range(0, 255)) : SYNC, 1);
    model();
    do_reset();
    play();
    for (int t = 0; t < n; t++) begin
      cmp++;
      if (obs[t] !== exp_o[t]) begin bad++; $display("FAIL back_to_back t=%0d got %h want %h", t, obs[t], exp_o[t]); end
    end
  endtask

  task automatic test_saturation();
    n = 0;
    push_rand(5);
    for (int r = 0; r < 130; r++) begin
      push_frame(SYNC, 0);
      push_frame(SYNC, 0);
      push_frame(16'hFFFF, 0);
      push_frame(16'hFFFF, 0);
    end
    model();
    do_reset();
    play();
    for (int t = 0; t < n; t++) begin
      cmp++;
      if (obs[t] !== exp_o[t]) begin bad++; $display("FAIL saturation t=%0d got %h want %h", t, obs[t], exp_o[t]); end
    end
    cmp++;
    if (obs[n - 1][23:16] !== (ERR_ON ? 8'hFF : 8'h00)) begin bad++; $display("FAIL saturation_final got %h want %h", obs[n - 1][23:16], ERR_ON ? 8'hFF : 8'h00); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_false_sync();
    test_miss_tolerance();
    test_sync_in_payload();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/des_sync.md
# des_sync

Serial-to-parallel receiver with frame synchronisation for the off-chip link; consumes the 1-bit MSB-first stream produced by the 16-to-1 serialiser stage and rebuilds 16-bit words. Hunts for a sync word, confirms frame alignment, then emits payload words with a one-cycle valid strobe. Sits directly downstream of the serialiser, on the receiving side of the link, and runs on the same clock.

## Interface
- SYNC_WORD, 16'hA5C3: frame marker, first word of every frame.
- FRAME_LEN, 8: words per frame including the sync word; legal range 2..256.
- MISS_MAX, 2: consecutive missed sync words in LOCK before dropping to HUNT; legal range 1..15.
- clk  input  1  rising-edge clock, one serial bit per cycle.
- rst  input  1  asynchronous, active-high reset.
- datain  input  1  serial bit, MSB of each word first.
- dataout  output  16  last payload word.
- valid  output  1  one-cycle strobe; dataout holds a new payload word.
- sof  output  1  high with valid on the first payload word of a frame (word index 1).
- locked  output  1  high while in LOCK.
- err_cnt  output  8  sync-miss counter (see Configuration).

## Operation
- The shift register captures datain every cycle. w = {shift_reg[14:0], datain} is the 16-bit window including the current bit.
- States: HUNT, CHECK, LOCK.
- HUNT: w is compared every cycle. When w == SYNC_WORD, go to CHECK, set bit_cnt = 0 and word_idx = 1. No output.
- Word completion: bit_cnt counts 0..15 and wraps. A word completes on the cycle bit_cnt == 15. word_idx advances mod FRAME_LEN on each completion.
- CHECK: at the completion with word_idx == 0, if w == SYNC_WORD go to LOCK with miss_cnt = 0; otherwise go to HUNT. Payload is never emitted in CHECK.
- LOCK, completion with word_idx != 0: dataout <= w, valid <= 1, sof <= (word_idx == 1).
- LOCK, completion with word_idx == 0: if match, miss_cnt = 0. On mismatch, miss_cnt increments; if it reaches MISS_MAX, go to HUNT. Sync words are never emitted, whether or not they match.
- On exit to HUNT, the counters are don't-care. Hunting restarts on the next cycle's window. No sync is ever detected on the same cycle that lock is lost.

## Timing
- Reset values: dataout = 16'h0000, valid = 0, sof = 0, locked = 0, err_cnt = 0, state = HUNT, shift_reg = 0, bit_cnt = 0, word_idx = 0, miss_cnt = 0.
- Latency: valid rises the cycle after the edge that samples the word's 16th bit. dataout is stable until the next valid.
- valid is high at most one cycle in every 16.
- locked is registered: it rises the cycle after the confirming sync completes and falls the cycle after the MISS_MAX-th miss.
- A sync pattern appearing inside payload while in LOCK or CHECK is ignored; only word_idx == 0 positions are checked.
- If reset asserts mid-word or mid-frame, all outputs clear immediately (asynchronously). After reset releases, the block hunts from scratch.
- No backpressure: the consumer must accept valid every 16 cycles.

## Configuration
- DES_SYNC_ERRCNT_EN defined: err_cnt increments on every sync mismatch while in LOCK (including the one that causes loss of lock). It saturates at 8'hFF and is cleared only by rst.
- DES_SYNC_ERRCNT_EN undefined: the counter logic is omitted and err_cnt is tied to 8'h00. The port is always present.

## Structure
- Package des_sync_pkg holds:
  - WORD_W = 16
  - the state enum (HUNT, CHECK, LOCK)
  - the default SYNC_WORD constant
- Sub-module des_sync_shift holds the 16-bit shift register, bit_cnt, and the window w output. It has a load-phase input that zeroes bit_cnt on detection.
- The top level holds the FSM, word_idx, miss_cnt, the output registers, and err_cnt.

## Test plan
- Clean lock: send random bit offset 5, then frames of A5C3 + 7 payload words (0001..0007), twice. Required: locked rises after the second sync. The second frame yields valid ×7, dataout 0001..0007, and sof only with 0001.
- False sync in CHECK: A5C3, then 7 words, then 1234 in the sync slot. Required: return to HUNT, locked stays 0, no valid.
- Miss tolerance: while locked, corrupt one sync (FFFF). Required: locked stays 1, payload continues, err_cnt = 1. Then corrupt two consecutive syncs. Required: locked falls the cycle after the second miss, err_cnt = 3.
- Sync pattern inside payload: while locked, send payload word A5C3 at index 3. Required: output as data with valid, and alignment is unchanged.
- Reset mid-frame: assert rst at bit 9 of payload word 4. Required: all outputs 0 immediately and state HUNT. A re-lock then needs two syncs.
- Saturation (macro defined): force more than 255 sync misses across re-locks. Required: err_cnt holds at 8'hFF. With the macro undefined, err_cnt stays 8'h00 throughout.
